// File: rtl/dispatch_credit_stage.sv
// Single-issue dispatch stage: input FIFO, per-RS credit tracking, ROB/LSQ tag allocation and stall reporting.
// Optional performance counters are enabled by defining DISPATCH_PERF_CNT_EN.
module dispatch_credit_stage #(
  parameter int XLEN      = 32,
  parameter int NUM_RS    = 5,
  parameter int RS_DEPTH  = 8,
  parameter int ROB_DEPTH = 64,
  parameter int LSQ_DEPTH = 16,
  parameter int BUF_DEPTH = 2,
  localparam int SW = $clog2(NUM_RS),
  localparam int RW = $clog2(ROB_DEPTH),
  localparam int LW = $clog2(LSQ_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [SW-1:0]     in_rs_sel,
  input  logic              in_is_mem,
  input  logic [NUM_RS-1:0] rs_free,
  input  logic              rob_retire,
  input  logic              lsq_retire,
  output logic [NUM_RS-1:0] rs_valid,
  output logic [31:0]       out_instr,
  output logic [XLEN-1:0]   out_pc,
  output logic [RW-1:0]     out_rob_tag,
  output logic [LW-1:0]     out_lsq_tag,
  output logic              out_is_mem,
  output logic [1:0]        stall_cause
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_dispatch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int BW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(RS_DEPTH + 1);
  localparam logic [CW-1:0] CREDIT_FULL = CW'(RS_DEPTH);
  localparam logic [BW:0]   BUF_FULL    = (BW + 1)'(BUF_DEPTH);
  localparam logic [RW:0]   ROB_FULL    = (RW + 1)'(ROB_DEPTH);
  localparam logic [LW:0]   LSQ_FULL    = (LW + 1)'(LSQ_DEPTH);

  logic [31:0]       buf_instr [BUF_DEPTH];
  logic [XLEN-1:0]   buf_pc    [BUF_DEPTH];
  logic [SW-1:0]     buf_sel   [BUF_DEPTH];
  logic              buf_mem   [BUF_DEPTH];

  logic [BW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BW:0]       buf_cnt_q, buf_cnt_d;
  logic [CW-1:0]     credit_q [NUM_RS];
  logic [CW-1:0]     credit_d [NUM_RS];
  logic [NUM_RS-1:0] credit_dec, credit_inc;
  logic [RW-1:0]     rob_ptr_q, rob_ptr_d;
  logic [RW:0]       rob_cnt_q, rob_cnt_d;
  logic [LW-1:0]     lsq_ptr_q, lsq_ptr_d;
  logic [LW:0]       lsq_cnt_q, lsq_cnt_d;
  logic [NUM_RS-1:0] rs_valid_q, rs_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [XLEN-1:0]   out_pc_q, out_pc_d;
  logic [RW-1:0]     out_rob_tag_q, out_rob_tag_d;
  logic [LW-1:0]     out_lsq_tag_q, out_lsq_tag_d;
  logic              out_is_mem_q, out_is_mem_d;
  logic [1:0]        stall_cause_q, stall_cause_d;

  logic              fifo_full, fifo_empty, push, dispatch, lsq_alloc;
  logic              head_credit_ok, rob_full, lsq_full;
  logic [31:0]       head_instr;
  logic [XLEN-1:0]   head_pc;
  logic [SW-1:0]     head_sel;
  logic              head_mem;

  assign fifo_full  = (buf_cnt_q == BUF_FULL);
  assign fifo_empty = (buf_cnt_q == '0);
  assign in_ready   = !fifo_full && !flush;
  assign push       = in_valid && in_ready;

  assign head_instr = buf_instr[rd_ptr_q];
  assign head_pc    = buf_pc[rd_ptr_q];
  assign head_sel   = buf_sel[rd_ptr_q];
  assign head_mem   = buf_mem[rd_ptr_q];

  assign rob_full  = (rob_cnt_q == ROB_FULL);
  assign lsq_full  = (lsq_cnt_q == LSQ_FULL);

  // An out-of-range selector matches no channel, so it reads as "no credit" and never dispatches.
  always_comb begin
    head_credit_ok = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (head_sel == SW'(i)) head_credit_ok = (credit_q[i] != '0);
    end
  end

  assign dispatch  = !flush && !fifo_empty && head_credit_ok && !rob_full && (!head_mem || !lsq_full);
  assign lsq_alloc = dispatch && head_mem;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RS; gi++) begin : g_credit
      assign credit_dec[gi] = dispatch && (head_sel == SW'(gi));
      // A free pulse at full credit is dropped unless the same channel is consuming this cycle.
      assign credit_inc[gi] = rs_free[gi] && ((credit_q[gi] != CREDIT_FULL) || credit_dec[gi]);
      assign credit_d[gi]   = flush ? CREDIT_FULL
                                    : credit_q[gi] - CW'(credit_dec[gi]) + CW'(credit_inc[gi]);

      a_rs_free_overflow: assert property (@(posedge clk) disable iff (rst || flush)
        rs_free[gi] |-> (credit_q[gi] != CREDIT_FULL));
    end
  endgenerate

  always_comb begin
    wr_ptr_d      = wr_ptr_q + BW'(push);
    rd_ptr_d      = rd_ptr_q + BW'(dispatch);
    buf_cnt_d     = buf_cnt_q + (BW + 1)'(push) - (BW + 1)'(dispatch);
    rob_ptr_d     = rob_ptr_q + RW'(dispatch);
    rob_cnt_d     = rob_cnt_q + (RW + 1)'(dispatch) - (RW + 1)'(rob_retire && (rob_cnt_q != '0));
    lsq_ptr_d     = lsq_ptr_q + LW'(lsq_alloc);
    lsq_cnt_d     = lsq_cnt_q + (LW + 1)'(lsq_alloc) - (LW + 1)'(lsq_retire && (lsq_cnt_q != '0));
    rs_valid_d    = credit_dec;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    out_rob_tag_d = out_rob_tag_q;
    out_lsq_tag_d = out_lsq_tag_q;
    out_is_mem_d  = out_is_mem_q;
    stall_cause_d = 2'd0;

    if (dispatch) begin
      out_instr_d   = head_instr;
      out_pc_d      = head_pc;
      out_rob_tag_d = rob_ptr_q;
      out_lsq_tag_d = lsq_ptr_q;
      out_is_mem_d  = head_mem;
    end else if (!flush && !fifo_empty) begin
      if (!head_credit_ok)  stall_cause_d = 2'd1;
      else if (rob_full)    stall_cause_d = 2'd2;
      else                  stall_cause_d = 2'd3;
    end

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      buf_cnt_d  = '0;
      rob_ptr_d  = '0;
      rob_cnt_d  = '0;
      lsq_ptr_d  = '0;
      lsq_cnt_d  = '0;
      rs_valid_d = '0;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr_q] <= in_instr;
      buf_pc[wr_ptr_q]    <= in_pc;
      buf_sel[wr_ptr_q]   <= in_rs_sel;
      buf_mem[wr_ptr_q]   <= in_is_mem;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      buf_cnt_q     <= '0;
      rob_ptr_q     <= '0;
      rob_cnt_q     <= '0;
      lsq_ptr_q     <= '0;
      lsq_cnt_q     <= '0;
      rs_valid_q    <= '0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      out_rob_tag_q <= '0;
      out_lsq_tag_q <= '0;
      out_is_mem_q  <= 1'b0;
      stall_cause_q <= 2'd0;
      for (int i = 0; i < NUM_RS; i++) credit_q[i] <= CREDIT_FULL;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      buf_cnt_q     <= buf_cnt_d;
      rob_ptr_q     <= rob_ptr_d;
      rob_cnt_q     <= rob_cnt_d;
      lsq_ptr_q     <= lsq_ptr_d;
      lsq_cnt_q     <= lsq_cnt_d;
      rs_valid_q    <= rs_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      out_rob_tag_q <= out_rob_tag_d;
      out_lsq_tag_q <= out_lsq_tag_d;
      out_is_mem_q  <= out_is_mem_d;
      stall_cause_q <= stall_cause_d;
      for (int i = 0; i < NUM_RS; i++) credit_q[i] <= credit_d[i];
    end
  end

  assign rs_valid    = rs_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign out_rob_tag = out_rob_tag_q;
  assign out_lsq_tag = out_lsq_tag_q;
  assign out_is_mem  = out_is_mem_q;
  assign stall_cause = stall_cause_q;

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] perf_dispatch_q, perf_dispatch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Counters survive flush; only rst clears them.
  always_comb begin
    perf_dispatch_d = perf_dispatch_q + 32'(dispatch);
    perf_stall_d    = perf_stall_q + 32'(stall_cause_q != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_dispatch_q <= '0;
      perf_stall_q    <= '0;
    end else begin
      perf_dispatch_q <= perf_dispatch_d;
      perf_stall_q    <= perf_stall_d;
    end
  end

  assign perf_dispatch_cnt = perf_dispatch_q;
  assign perf_stall_cnt    = perf_stall_q;
`endif

  a_rs_sel_legal: assert property (@(posedge clk) disable iff (rst)
    (in_valid && in_ready) |-> (32'(in_rs_sel) < 32'(NUM_RS)));
  a_rob_underflow: assert property (@(posedge clk) disable iff (rst || flush)
    rob_retire |-> (rob_cnt_q != '0));
  a_lsq_underflow: assert property (@(posedge clk) disable iff (rst || flush)
    lsq_retire |-> (lsq_cnt_q != '0));

endmodule

// File: tb/tb_dispatch_credit_stage.sv
// Directed bench for dispatch_credit_stage: credit exhaustion, ROB/LSQ tag wrap and full stalls, flush.
// Perf-counter checks are compiled only when DISPATCH_PERF_CNT_EN is defined.
module tb_dispatch_credit_stage;

  localparam int NUM_RS = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [31:0]       in_pc;
  logic [2:0]        in_rs_sel;
  logic              in_is_mem;
  logic [NUM_RS-1:0] rs_free;
  logic [NUM_RS-1:0] rs_free_dir;
  logic [NUM_RS-1:0] rs_free_echo;
  logic              rob_retire;
  logic              lsq_retire;
  logic [NUM_RS-1:0] rs_valid;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic [5:0]        out_rob_tag;
  logic [3:0]        out_lsq_tag;
  logic              out_is_mem;
  logic [1:0]        stall_cause;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0]       perf_dispatch_cnt;
  logic [31:0]       perf_stall_cnt;
`endif

  typedef struct {
    int          sel;
    int          rob_tag;
    int          lsq_tag;
    int          is_mem;
    logic [31:0] pc;
  } disp_t;

  disp_t log_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  bit    echo_en  = 1'b0;

  assign rs_free = rs_free_dir | rs_free_echo;

  always #5 clk = ~clk;

  dispatch_credit_stage dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs_sel   (in_rs_sel),
    .in_is_mem   (in_is_mem),
    .rs_free     (rs_free),
    .rob_retire  (rob_retire),
    .lsq_retire  (lsq_retire),
    .rs_valid    (rs_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_rob_tag (out_rob_tag),
    .out_lsq_tag (out_lsq_tag),
    .out_is_mem  (out_is_mem),
    .stall_cause (stall_cause)
`ifdef DISPATCH_PERF_CNT_EN
    ,
    .perf_dispatch_cnt (perf_dispatch_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Records every strobe; optionally returns the credit one cycle later like an RS issuing at once.
  always @(negedge clk) begin
    rs_free_echo = '0;
    if (!rst && (rs_valid != '0)) begin
      int idx;
      disp_t d;
      idx = -1;
      for (int i = 0; i < NUM_RS; i++) if (rs_valid[i]) idx = i;
      check_val("strobe_onehot", 64'($countones(rs_valid)), 64'd1);
      d.sel = idx; d.rob_tag = int'(out_rob_tag); d.lsq_tag = int'(out_lsq_tag);
      d.is_mem = int'(out_is_mem); d.pc = out_pc;
      log_q.push_back(d);
      $display("dispatch #%0d rs=%0d rob_tag=%0d lsq_tag=%0d mem=%0d pc=0x%08h",
               log_q.size() - 1, idx, d.rob_tag, d.lsq_tag, d.is_mem, d.pc);
      if (echo_en) rs_free_echo = rs_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    in_rs_sel = '0; in_is_mem = 1'b0; rs_free_dir = '0; rob_retire = 1'b0;
    lsq_retire = 1'b0; echo_en = 1'b0;
    tick(2);
    rst = 1'b0;
    log_q.delete();
  endtask

  // Offers ops first..last-1 (sel_mode<0 cycles over the RS), stopping after max_cycles.
  task automatic send_ops(input int first, input int last, input int sel_mode, input bit mem,
                          input int max_cycles, output int next);
    int  k;
    int  cyc;
    bit  acc;
    k = first; cyc = 0;
    while (k < last && cyc < max_cycles) begin
      in_valid  = 1'b1;
      in_pc     = 32'h1000 + 32'(k * 4);
      in_instr  = 32'hA500_0000 | 32'(k);
      in_rs_sel = (sel_mode < 0) ? 3'(k % NUM_RS) : 3'(sel_mode);
      in_is_mem = mem;
      acc = in_ready;
      tick(1);
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0;
    next = k;
  endtask

  initial begin
    int nx;
    bit seen;

    // Reset state
    do_reset();
    @(negedge clk);
    check_val("rst_rs_valid", 64'(rs_valid), 64'd0);
    check_val("rst_stall", 64'(stall_cause), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_rob_tag", 64'(out_rob_tag), 64'd0);
    check_val("rst_out_instr", 64'(out_instr), 64'd0);
    tick(1);

    // Ten ALU ops without credit return: eight dispatch, then RS-full with a full FIFO
    send_ops(0, 10, 0, 1'b0, 30, nx);
    check_val("alu_accepted", 64'(nx), 64'd10);
    tick(3);
    @(negedge clk);
    check_val("alu_disp_count", 64'(log_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check_val("alu_rob_tag", 64'(log_q[i].rob_tag), 64'(i));
      check_val("alu_pc", 64'(log_q[i].pc), 64'(32'h1000 + i * 4));
    end
    check_val("alu_stall_rs", 64'(stall_cause), 64'd1);
    check_val("alu_in_ready_full", 64'(in_ready), 64'd0);
    tick(1);

    // One credit returned: exactly one more dispatch, visible two cycles after the pulse
    log_q.delete();
    rs_free_dir = 5'b00001;
    @(posedge clk); #1;
    rs_free_dir = '0;
    @(negedge clk);
    check_val("free_not_same_cycle", 64'(rs_valid), 64'd0);
    @(negedge clk);
    check_val("free_strobe", 64'(rs_valid), 64'd1);
    check_val("free_rob_tag", 64'(out_rob_tag), 64'd8);
    check_val("free_pc", 64'(out_pc), 64'h1020);
    check_val("free_stall_clear", 64'(stall_cause), 64'd0);
    tick(4);
    @(negedge clk);
    check_val("free_one_more", 64'(log_q.size()), 64'd1);
    check_val("free_in_ready", 64'(in_ready), 64'd1);
    check_val("free_stall_again", 64'(stall_cause), 64'd1);
    tick(1);

    // 70 ops round-robin with echoed credits; ROB fills at 64 and tags wrap after retirement
    do_reset();
    echo_en = 1'b1;
    send_ops(0, 70, -1, 1'b0, 80, nx);
    check_val("rob_accepted", 64'(nx), 64'd66);
    tick(2);
    @(negedge clk);
    check_val("rob_stall_full", 64'(stall_cause), 64'd2);
    check_val("rob_disp_64", 64'(log_q.size()), 64'd64);
    check_val("rob_last_tag", 64'(log_q[63].rob_tag), 64'd63);
    tick(1);
    rob_retire = 1'b1;
    tick(6);
    rob_retire = 1'b0;
    send_ops(nx, 70, -1, 1'b0, 40, nx);
    check_val("rob_accepted_all", 64'(nx), 64'd70);
    tick(5);
    @(negedge clk);
    check_val("rob_disp_70", 64'(log_q.size()), 64'd70);
    if (log_q.size() == 70) begin
      for (int i = 0; i < 70; i++) check_val("rob_sel", 64'(log_q[i].sel), 64'(i % NUM_RS));
      for (int i = 60; i < 70; i++) check_val("rob_wrap_tag", 64'(log_q[i].rob_tag), 64'(i % 64));
    end
    check_val("rob_idle_stall", 64'(stall_cause), 64'd0);
    echo_en = 1'b0;
    tick(2);

    // 17 stores with no LSQ release: sixteen tags then LSQ-full
    do_reset();
    echo_en = 1'b1;
    send_ops(0, 17, 1, 1'b1, 40, nx);
    check_val("lsq_accepted", 64'(nx), 64'd17);
    tick(3);
    @(negedge clk);
    check_val("lsq_disp_16", 64'(log_q.size()), 64'd16);
    if (log_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check_val("lsq_tag", 64'(log_q[i].lsq_tag), 64'(i));
        check_val("lsq_is_mem", 64'(log_q[i].is_mem), 64'd1);
      end
    end
    check_val("lsq_stall_full", 64'(stall_cause), 64'd3);
    check_val("lsq_in_ready", 64'(in_ready), 64'd1);
    echo_en = 1'b0;
    tick(2);

    // Flush with a full FIFO and exhausted credit on channel 0
    do_reset();
    send_ops(0, 10, 0, 1'b0, 30, nx);
    tick(2);
    flush = 1'b1; in_valid = 1'b1; rs_free_dir = 5'b00001;
    #1;
    check_val("flush_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; rs_free_dir = '0;
    @(negedge clk);
    check_val("flush_in_ready", 64'(in_ready), 64'd1);
    check_val("flush_rs_valid", 64'(rs_valid), 64'd0);
    check_val("flush_stall", 64'(stall_cause), 64'd0);
    log_q.delete();
    tick(1);
    send_ops(100, 108, 0, 1'b0, 30, nx);
    tick(4);
    @(negedge clk);
    check_val("flush_disp_8", 64'(log_q.size()), 64'd8);
    if (log_q.size() == 8) begin
      check_val("flush_first_tag", 64'(log_q[0].rob_tag), 64'd0);
      check_val("flush_last_tag", 64'(log_q[7].rob_tag), 64'd7);
      check_val("flush_first_pc", 64'(log_q[0].pc), 64'(32'h1000 + 400));
    end
    check_val("flush_empty_stall", 64'(stall_cause), 64'd0);
    tick(1);

`ifdef DISPATCH_PERF_CNT_EN
    // Eight dispatches, then exactly five RS-full cycles ended by a flush
    do_reset();
    send_ops(0, 9, 0, 1'b0, 20, nx);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (stall_cause == 2'd1) seen = 1'b1;
    end
    check_val("perf_stall_seen", 64'(seen), 64'd1);
    check_val("perf_stall_start", 64'(perf_stall_cnt), 64'd0);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_val("perf_dispatch", 64'(perf_dispatch_cnt), 64'd8);
    check_val("perf_stall", 64'(perf_stall_cnt), 64'd5);
    tick(3);
    @(negedge clk);
    check_val("perf_dispatch_kept", 64'(perf_dispatch_cnt), 64'd8);
    check_val("perf_stall_kept", 64'(perf_stall_cnt), 64'd5);
`else
    seen = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
